wb_mem_responder: RTL

WB_MEM_RESPONDER -- requirements
Module: wb_mem_responder

---
 rtl/wb_mem_responder_pkg.sv | 25 ++
 rtl/wb_mem_responder_if.sv | 27 ++
 rtl/wb_mem_responder_ram.sv | 39 +++
 rtl/wb_mem_responder.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/wb_mem_responder_pkg.sv
// Shared types and widths for the Wishbone memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package wb_resp_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W  = 4;
    localparam int WB_ADDR_W = 32;

    // Responder FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } wb_state_e;

    // One captured Wishbone request.
    typedef struct packed {
        logic                 we;
        logic [WB_SEL_W-1:0]  sel;
        logic [WB_ADDR_W-1:0] adr;
        logic [WB_DATA_W-1:0] dat;
    } wb_req_t;

endpackage

// File: rtl/wb_mem_responder_if.sv
// Wishbone classic bus bundle between an initiator and the memory responder.
// Latency: n/a (wires only).
// Backpressure: responder stalls the initiator by withholding ack_o/err_o.
interface wb_mem_responder_if;
    import wb_resp_pkg::*;

    logic                 cyc_i;
    logic                 stb_i;
    logic                 we_i;
    logic [WB_SEL_W-1:0]  sel_i;
    logic [WB_ADDR_W-1:0] adr_i;
    logic [WB_DATA_W-1:0] dat_i;
    logic [WB_DATA_W-1:0] dat_o;
    logic                 ack_o;
    logic                 err_o;

    modport slave (
        input  cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
        output dat_o, ack_o, err_o
    );

    modport master (
        output cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
        input  dat_o, ack_o, err_o
    );

endinterface

// File: rtl/wb_mem_responder_ram.sv
// Single-port word RAM with per-byte write enables.
// Latency: one cycle; read data registered on the enabled edge (old data on write).
// Backpressure: none; accepts an access on every enabled edge.
module wb_resp_ram
    import wb_resp_pkg::*;
#(
    parameter int WORDS    = 1024,
    parameter int AW       = $clog2(WORDS),
    parameter     MEM_FILE = ""
) (
    input  logic                 clk_i,
    input  logic                 en_i,
    input  logic                 we_i,
    input  logic [WB_SEL_W-1:0]  be_i,
    input  logic [AW-1:0]        addr_i,
    input  logic [WB_DATA_W-1:0] wdat_i,
    output logic [WB_DATA_W-1:0] rdat_o
);

    logic [WB_DATA_W-1:0] mem_q [WORDS];
    logic [WB_DATA_W-1:0] rdat_q;

    // Byte-masked write and registered read of the addressed word.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < WB_SEL_W; b++) begin
                    if (be_i[b]) begin
                        mem_q[addr_i][8*b +: 8] <= wdat_i[8*b +: 8];
                    end
                end
            end
            rdat_q <= mem_q[addr_i];
        end
    end

    assign rdat_o = rdat_q;

endmodule

// File: rtl/wb_mem_responder.sv
// Wishbone classic (non-pipelined) responder in front of a local word memory.
// Latency: ack/err on the WAIT_CYCLES-th edge after the capture edge (capture edge itself when 0).
// Backpressure: one transaction per WAIT_CYCLES+2 cycles; dropping cyc_i aborts a pending one.
module wb_mem_responder
    import wb_resp_pkg::*;
#(
    parameter int                   MEM_WORDS   = 1024,
    parameter int                   WAIT_CYCLES = 1,
    parameter logic [WB_ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter                       MEM_FILE    = ""
) (
    input  logic                sys_clk,
    input  logic                rst_n,
    wb_mem_responder_if.slave   wb
);

    localparam int                   AW        = $clog2(MEM_WORDS);
    localparam logic [3:0]           WAIT_LD   = 4'(WAIT_CYCLES);
    localparam logic [WB_ADDR_W-2:0] WORDS_LIM = MEM_WORDS[WB_ADDR_W-2:0];

    wb_state_e            state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    wb_req_t              req_q, req_d;
    wb_req_t              live_req;
    wb_req_t              eff_req;
    logic [WB_DATA_W-1:0] dat_q, dat_d;

    logic [WB_ADDR_W-1:0] off_w;
    logic [WB_ADDR_W-3:0] idx_w;
    logic                 oor_w;
    logic                 go_resp;
    logic                 ram_en;
    logic                 ram_we;
    logic [WB_DATA_W-1:0] ram_rdat;
    logic                 unused_off;

    assign live_req = '{we: wb.we_i, sel: wb.sel_i, adr: wb.adr_i, dat: wb.dat_i};

    // In IDLE the live bus feeds the RAM so a zero-wait access commits on the
    // capture edge; everywhere else the captured request is the source.
    always_comb begin
        eff_req = req_q;
        if (state_q == ST_IDLE) begin
            eff_req = live_req;
        end
    end

    // Offset wraps modulo 2^32, so addresses below BASE_ADDR land far out of range.
    assign off_w      = eff_req.adr - BASE_ADDR;
    assign idx_w      = off_w[WB_ADDR_W-1:2];
    assign oor_w      = {1'b0, idx_w} >= WORDS_LIM;
    assign unused_off = &{1'b0, off_w[1:0]};

    // Next-state logic: capture, count down wait states, abort on cyc_i loss.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        go_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wb.cyc_i && wb.stb_i) begin
                    req_d = live_req;
                    cnt_d = WAIT_LD;
                    if (WAIT_LD == 4'd0) begin
                        state_d = ST_RESP;
                        go_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // stb_i may drop here; only cyc_i ends the cycle early.
                if (!wb.cyc_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_d = ST_RESP;
                        go_resp = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                // Always one idle edge after a response; no back-to-back accept.
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // The RAM is touched only on the edge entering RESP and only when in range.
    assign ram_en = go_resp && !oor_w;
    assign ram_we = ram_en && eff_req.we;

    wb_resp_ram #(
        .WORDS    (MEM_WORDS),
        .AW       (AW),
        .MEM_FILE (MEM_FILE)
    ) u_ram (
        .clk_i  (sys_clk),
        .en_i   (ram_en),
        .we_i   (ram_we),
        .be_i   (eff_req.sel),
        .addr_i (idx_w[AW-1:0]),
        .wdat_i (eff_req.dat),
        .rdat_o (ram_rdat)
    );

    // Read data shows during RESP, zero on an error, otherwise the last value holds.
    always_comb begin
        dat_d = dat_q;
        if (state_q == ST_RESP) begin
            if (oor_w) begin
                dat_d = '0;
            end else if (!req_q.we) begin
                dat_d = ram_rdat;
            end
        end
    end

    // State, counter, captured request and held read data.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            req_q   <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            dat_q   <= dat_d;
        end
    end

    assign wb.dat_o = dat_d;
    assign wb.ack_o = (state_q == ST_RESP) && !oor_w;
    assign wb.err_o = (state_q == ST_RESP) && oor_w;

endmodule
